// File: rtl/eq_band_mixer_if.sv
// Handshake bundle for eq_band_mixer: band samples and controls in, mixed stereo out.
// The master side drives stimulus; the slave side is the mixer itself.
interface eq_band_mixer_if #(
  parameter int NUM_BANDS = 5,
  parameter int NUM_CH    = 2,
  parameter int DW        = 16,
  parameter int POT_W     = 12
);
  logic [NUM_CH*NUM_BANDS*DW-1:0] band_in;
  logic                           in_vld;
  logic                           in_rdy;
  logic [NUM_BANDS*POT_W-1:0]     POT;
  logic [POT_W-1:0]               VOLUME;
  logic                           mute;
  logic [NUM_CH*DW-1:0]           aud_out;
  logic                           out_vld;
  logic                           out_rdy;
  logic                           clip;
  logic                           clr_clip;

  modport master (
    output band_in, in_vld, POT, VOLUME, mute, out_rdy, clr_clip,
    input  in_rdy, aud_out, out_vld, clip
  );

  modport slave (
    input  band_in, in_vld, POT, VOLUME, mute, out_rdy, clr_clip,
    output in_rdy, aud_out, out_vld, clip
  );
endinterface

// File: rtl/eq_band_mixer.sv
// Graphic-EQ band mixer: per-channel weighted sum of band samples, master volume,
// saturation with a sticky clip flag, all through one shared signed multiplier.
module eq_band_mixer #(
  parameter int NUM_BANDS = 5,
  parameter int NUM_CH    = 2,
  parameter int DW        = 16,
  parameter int POT_W     = 12
) (
  input  logic            clk,
  input  logic            rst,
  eq_band_mixer_if.slave  bus
);
  localparam int AW  = DW + 3 + $clog2(NUM_BANDS);
  localparam int PW  = AW + POT_W + 1;
  localparam int BW  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NS  = NUM_CH * NUM_BANDS;
  localparam logic signed [PW-1:0] SAT_HI = PW'((2 ** (DW - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, ACCUM, VOL, OUT} state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           band_q, band_d;
  logic [CHW-1:0]          ch_q, ch_d;
  logic [CHW-1:0]          store_ch_q, store_ch_d;
  logic                    store_pend_q, store_pend_d;
  logic signed [DW-1:0]    samp_q [NS];
  logic signed [DW-1:0]    samp_d [NS];
  logic [POT_W-1:0]        pot_q [NUM_BANDS];
  logic [POT_W-1:0]        pot_d [NUM_BANDS];
  logic [POT_W-1:0]        vol_q, vol_d;
  logic                    mute_q, mute_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [PW-1:0]    vprod_q, vprod_d;
  logic signed [DW-1:0]    aud_q [NUM_CH];
  logic signed [DW-1:0]    aud_d [NUM_CH];
  logic                    out_vld_q, out_vld_d;
  logic                    clip_q, clip_d;

  logic signed [DW-1:0]    band_w [NS];
  logic [POT_W-1:0]        pot_w [NUM_BANDS];
  logic signed [AW-1:0]    mul_a;
  logic signed [POT_W:0]   mul_b;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    term;
  logic signed [PW-1:0]    vsh;
  logic                    clip_set;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_band
      assign band_w[gi] = bus.band_in[gi*DW +: DW];
    end
    for (gi = 0; gi < NUM_BANDS; gi++) begin : g_pot
      assign pot_w[gi] = bus.POT[gi*POT_W +: POT_W];
    end
    for (gi = 0; gi < NUM_CH; gi++) begin : g_out
      assign bus.aud_out[gi*DW +: DW] = aud_q[gi];
    end
  endgenerate

  assign bus.in_rdy  = (state_q == IDLE);
  assign bus.out_vld = out_vld_q;
  assign bus.clip    = clip_q;

  // Single multiplier: band gain while accumulating, master volume in VOL.
  always_comb begin
    if (state_q == VOL) begin
      mul_a = acc_q;
      mul_b = {1'b0, vol_q};
    end else begin
      mul_a = AW'(samp_q[int'(ch_q) * NUM_BANDS + int'(band_q)]);
      mul_b = {1'b0, pot_q[band_q]};
    end
    prod = PW'(mul_a) * PW'(mul_b);
    term = AW'(prod >>> (POT_W - 2));
  end

  // Volume product is registered; the scaled result lands one cycle after VOL.
  assign vsh = vprod_q >>> POT_W;

  always_comb begin
    state_d      = state_q;
    band_d       = band_q;
    ch_d         = ch_q;
    store_ch_d   = store_ch_q;
    store_pend_d = 1'b0;
    samp_d       = samp_q;
    pot_d        = pot_q;
    vol_d        = vol_q;
    mute_d       = mute_q;
    acc_d        = acc_q;
    vprod_d      = vprod_q;
    aud_d        = aud_q;
    out_vld_d    = out_vld_q;
    clip_set     = 1'b0;

    if (store_pend_q) begin
      if (mute_q) begin
        aud_d[store_ch_q] = '0;
      end else if (vsh > SAT_HI) begin
        aud_d[store_ch_q] = DW'(SAT_HI);
        clip_set          = 1'b1;
      end else if (vsh < SAT_LO) begin
        aud_d[store_ch_q] = DW'(SAT_LO);
        clip_set          = 1'b1;
      end else begin
        aud_d[store_ch_q] = DW'(vsh);
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.in_vld) begin
          samp_d  = band_w;
          pot_d   = pot_w;
          vol_d   = bus.VOLUME;
          mute_d  = bus.mute;
          acc_d   = '0;
          band_d  = '0;
          ch_d    = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + term;
        if (band_q == BW'(NUM_BANDS - 1)) begin
          band_d  = '0;
          state_d = VOL;
        end else begin
          band_d = band_q + 1'b1;
        end
      end
      VOL: begin
        vprod_d      = prod;
        acc_d        = '0;
        store_pend_d = 1'b1;
        store_ch_d   = ch_q;
        if (ch_q == CHW'(NUM_CH - 1)) begin
          state_d = OUT;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = ACCUM;
        end
      end
      OUT: begin
        if (store_pend_q) begin
          out_vld_d = 1'b1;
        end else if (out_vld_q && bus.out_rdy) begin
          out_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    clip_d = clip_set | (clip_q & ~bus.clr_clip);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      band_q       <= '0;
      ch_q         <= '0;
      store_ch_q   <= '0;
      store_pend_q <= 1'b0;
      samp_q       <= '{default: '0};
      pot_q        <= '{default: '0};
      vol_q        <= '0;
      mute_q       <= 1'b0;
      acc_q        <= '0;
      vprod_q      <= '0;
      aud_q        <= '{default: '0};
      out_vld_q    <= 1'b0;
      clip_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      band_q       <= band_d;
      ch_q         <= ch_d;
      store_ch_q   <= store_ch_d;
      store_pend_q <= store_pend_d;
      samp_q       <= samp_d;
      pot_q        <= pot_d;
      vol_q        <= vol_d;
      mute_q       <= mute_d;
      acc_q        <= acc_d;
      vprod_q      <= vprod_d;
      aud_q        <= aud_d;
      out_vld_q    <= out_vld_d;
      clip_q       <= clip_d;
    end
  end
endmodule

// File: doc/eq_band_mixer.md
EQ_BAND_MIXER -- requirements
Module: eq_band_mixer

Interface
REQ-001 Parameters: NUM_BANDS, default 5, band count; NUM_CH, default 2, channel count; DW, default 16, sample width; POT_W, default 12, slider width.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 band_in  in  NUM_CH*NUM_BANDS*DW  signed filtered band samples; channel c, band b at [(c*NUM_BANDS+b)*DW +: DW].
REQ-006 in_vld  in  1  band_in valid.
REQ-007 in_rdy  out  1  block can accept a sample set.
REQ-008 POT  in  NUM_BANDS*POT_W  unsigned per-band gain sliders; band b at [b*POT_W +: POT_W].
REQ-009 VOLUME  in  POT_W  unsigned master volume.
REQ-010 mute  in  1  force zero output for the accepted set.
REQ-011 aud_out  out  NUM_CH*DW  signed mixed output; channel c at [c*DW +: DW].
REQ-012 out_vld  out  1  aud_out valid.
REQ-013 out_rdy  in  1  downstream accepts aud_out.
REQ-014 clip  out  1  sticky saturation flag.
REQ-015 clr_clip  in  1  clears clip.

Function
REQ-016 Accept occurs on a cycle with in_vld=1 and in_rdy=1; band_in, POT, VOLUME, mute are captured on accept and held internally for the whole computation.
REQ-017 States: IDLE (in_rdy=1), ACCUM, VOL, OUT; one shared signed multiplier; no other multipliers.
REQ-018 IDLE -> ACCUM on accept; ACCUM spends NUM_BANDS cycles per channel, one band per cycle, band 0 first; ACCUM -> VOL after last band; VOL one cycle; VOL -> ACCUM (next channel) or -> OUT after channel NUM_CH-1.
REQ-019 Band term = (sample * {1'b0,POT_b}) >>> (POT_W-2), arithmetic shift (floor); POT=2^(POT_W-2) is unity gain, maximum gain just under 4.
REQ-020 Accumulator width DW+3+clog2(NUM_BANDS) bits signed, cleared at start of each channel; no overflow possible.
REQ-021 Channel result = (acc * {1'b0,VOLUME}) >>> POT_W (floor), then saturated to [-2^(DW-1), 2^(DW-1)-1].
REQ-022 If captured mute=1, all channel results are 0 and clip is not set.
REQ-023 clip sets on any saturating channel result; clr_clip clears it; set has priority when both occur in the same cycle.
REQ-024 Latency: out_vld asserts NUM_CH*(NUM_BANDS+1)+1 cycles after the accept edge (13 at defaults).
REQ-025 OUT: out_vld=1, aud_out stable, held until out_vld&out_rdy; transfer cycle returns to IDLE, in_rdy=1 on the following cycle.
REQ-026 in_rdy=0 in ACCUM, VOL, OUT; in_vld in those states is ignored, no sample loss tracking.
REQ-027 Changes of POT, VOLUME, mute, band_in after accept have no effect on the in-flight result.

Reset
REQ-028 rst=1 on a rising edge: state IDLE, accumulator 0, aud_out 0, out_vld 0, clip 0, in_rdy 1 from the next cycle.
REQ-029 rst mid-computation or in OUT aborts the set; no out_vld for it.

Verification (defaults)
REQ-030 All ch0 bands 1000, ch1 bands -1000, all POT 1024, VOLUME 2048 -> aud_out ch0 2500, ch1 -2500, out_vld exactly 13 cycles after accept, clip 0.
REQ-031 All bands 30000 / -30000 on ch0 / ch1, POT 4095, VOLUME 4095 -> ch0 32767, ch1 -32768, clip 1 and stays 1 until clr_clip.
REQ-032 Floor check: single band -1 others 0, POT 1, VOLUME 4095 -> band term -1, output -1 (not 0).
REQ-033 Backpressure: out_rdy=0 for 20 cycles after out_vld -> aud_out stable, in_rdy 0, in_vld pulses ignored; out_rdy=1 -> transfer, in_rdy 1 next cycle.
REQ-034 Mute set on accept with REQ-030 stimulus -> outputs 0, clip unchanged; POT changed to 0 during ACCUM -> no effect.
REQ-035 rst asserted 5 cycles after accept -> out_vld never asserts for that set, in_rdy 1 one cycle after reset release, next set processes normally.
